z8086_sram_bridge: RTL and testbench
====================================

// Module: z8086_sram_bridge
// PURPOSE
//  Downstream of z8086: turns the CPU simplified bus (addr/din/dout/rd/wr/io/word/ready) into cycles on a
//  byte-wide async SRAM, plus a strobe-style I/O port. Word accesses become two byte cycles (A, then A+1).
//  This is the synthesizable replacement for the bench memory model; it keeps the same CPU-side handshake.
// PARAMETERS
//  WAIT_STATES  1  extra cycles per SRAM byte phase (0..7); each phase lasts WAIT_STATES+1 cycles
// PORTS
//  clk        in   1   single system clock; everything on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  addr       in   20  CPU physical address (I/O: addr[15:0] is port)
//  dout       in   16  CPU write data (byte writes use [7:0])
//  din        out  16  read data to CPU; valid only while ready=1, else 16'h0000
//  rd, wr     in   1   single-cycle request pulses from CPU
//  io         in   1   1=I/O space, 0=memory; sampled with rd/wr
//  word       in   1   1=16-bit access, 0=8-bit; sampled with rd/wr
//  ready      out  1   one-cycle completion pulse (reads and writes)
//  sram_addr  out  20  SRAM byte address
//  sram_dq_o  out  8   SRAM write data;  sram_dq_oe out 1: drive enable for dq
//  sram_dq_i  in   8   SRAM read data
//  sram_ce_n, sram_oe_n, sram_we_n  out 1 each  active-low SRAM strobes
//  io_addr    out  16  port number;  io_wdata out 16;  io_word out 1
//  io_rd, io_wr out 1  one-cycle I/O strobes;  io_rdata in 16: sampled the cycle after io_rd
// BEHAVIOUR
//  Reset (async): state IDLE; ready=0, din=0, sram_ce_n=oe_n=we_n=1, dq_oe=0, io_rd=io_wr=0, addrs/data 0.
//  Reset mid-transaction aborts it: no ready, no further strobes; request is lost.
//  FSM: IDLE -> B0 -> (word) B1 -> RESP -> IDLE; I/O path IDLE -> IOS -> IOW -> RESP.
//  IDLE: on rd|wr latch addr, dout, io, word, dir (wr wins if rd&wr both high; rd dropped).
//   rd/wr pulses seen outside IDLE are ignored (CPU must wait for ready). No strobes in IDLE.
//  B0: WAIT_STATES+1 cycles, sram_addr=A, ce_n=0. Read: oe_n=0, sram_dq_i captured into low byte
//   at final edge of phase. Write: dq_oe=1, dq_o=data[7:0], we_n=0 all cycles except the last
//   (we_n rises before address change; WAIT_STATES=0 -> we_n low for the single cycle).
//  B1 (word only): same as B0 with sram_addr=A+1 mod 2^20 (FFFFF wraps to 00000), byte [15:8].
//   One idle cycle (ce_n=1) is inserted between B0 and B1 for writes only.
//  RESP: ready=1 one cycle; read din={hi,lo}; byte read din={8'h00,lo}; write din=0. Then IDLE;
//   a new rd/wr in the RESP cycle is not accepted (earliest accept = cycle after ready).
//  IOS: one cycle io_rd or io_wr =1, io_addr=A[15:0], io_wdata=dout, io_word=word.
//  IOW: read captures io_rdata (byte: din={8'h00,io_rdata[7:0]}); write: no action. Then RESP.
//  Latency (request cycle = 0, W=WAIT_STATES): mem byte read ready in cycle W+2; word read 2W+3;
//   byte write W+2; word write 2W+4; I/O any 3.
//  Odd address, word access: no alignment restriction; bytes go to A and A+1 as above.
//  All outputs registered; no combinational path from CPU inputs to any output.
// TESTING
//  W=1, mem[0x12345]=0xAB,[0x12346]=0xCD; rd word @0x12345 -> ready cycle 5, din=0xCDAB, 1 pulse.
//  W=0, wr byte @0x00010 dout=0x77EE -> ready cycle 2, only 0x00010=0xEE written, 0x00011 unchanged.
//  W=1, wr word @0xFFFFF dout=0x1234 -> 0xFFFFF=0x34, 0x00000=0x12, ready cycle 6, we_n never low with addr change.
//  io rd port 0x0060, io_rdata=0xFFFF, byte -> io_rd pulse cycle 1 addr 0x0060, ready cycle 3, din=0x00FF.
//  rd and wr high together @0x100 dout=0x55 -> write performed, no read, single ready.
//  reset_n low during B1 of word write -> strobes deassert immediately, no ready, IDLE accepts after release.

Source files
------------

// File: rtl/z8086_sram_bridge_if.sv
// CPU-side simplified z8086 bus: request pulses plus attributes from the CPU,
// and a one-cycle ready pulse with read data from the bridge.
interface z8086_sram_bridge_if;
    logic [19:0] addr;
    logic [15:0] dout;
    logic [15:0] din;
    logic        rd;
    logic        wr;
    logic        io;
    logic        word;
    logic        ready;

    modport master (output addr, dout, rd, wr, io, word, input din, ready);
    modport slave  (input addr, dout, rd, wr, io, word, output din, ready);
endinterface

// File: rtl/z8086_sram_bridge.sv
// Bridges the z8086 CPU bus onto a byte-wide async SRAM and a strobe-style I/O port.
// Word accesses run as two byte phases (A, then A+1); every output is a flop.
//
//  state  | meaning
//  IDLE   | waiting for rd/wr; request attributes latched on acceptance
//  B0     | SRAM byte phase at A (low byte), WAIT_STATES+1 cycles
//  GAP    | one deselected cycle between write phases of a word write
//  B1     | SRAM byte phase at A+1 (high byte), word accesses only
//  RESP   | ready pulse with read data
//  IOS    | one-cycle io_rd / io_wr strobe
//  IOW    | io_rdata sampled (reads)
module z8086_sram_bridge #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    z8086_sram_bridge_if.slave   cpu,
    output logic [19:0]          sram_addr,
    output logic [7:0]           sram_dq_o,
    output logic                 sram_dq_oe,
    input  logic [7:0]           sram_dq_i,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [15:0]          io_addr,
    output logic [15:0]          io_wdata,
    output logic                 io_word,
    output logic                 io_rd,
    output logic                 io_wr,
    input  logic [15:0]          io_rdata
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE, S_B0, S_GAP, S_B1, S_RESP, S_IOS, S_IOW
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        word_q, word_d;
    logic        wr_q, wr_d;
    logic [7:0]  lo_q, lo_d;
    logic        last_phase;
    logic        mem_phase_d;

    logic [19:0] sram_addr_q, sram_addr_d;
    logic [7:0]  sram_dq_o_q, sram_dq_o_d;
    logic        sram_dq_oe_q, sram_dq_oe_d;
    logic        sram_ce_n_q, sram_ce_n_d;
    logic        sram_oe_n_q, sram_oe_n_d;
    logic        sram_we_n_q, sram_we_n_d;
    logic [15:0] io_addr_q, io_addr_d;
    logic [15:0] io_wdata_q, io_wdata_d;
    logic        io_word_q, io_word_d;
    logic        io_rd_q, io_rd_d;
    logic        io_wr_q, io_wr_d;
    logic        ready_q, ready_d;
    logic [15:0] din_q, din_d;

    assign last_phase = (cnt_q == 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            addr_q       <= 20'h0;
            data_q       <= 16'h0;
            word_q       <= 1'b0;
            wr_q         <= 1'b0;
            lo_q         <= 8'h0;
            sram_addr_q  <= 20'h0;
            sram_dq_o_q  <= 8'h0;
            sram_dq_oe_q <= 1'b0;
            sram_ce_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
            io_addr_q    <= 16'h0;
            io_wdata_q   <= 16'h0;
            io_word_q    <= 1'b0;
            io_rd_q      <= 1'b0;
            io_wr_q      <= 1'b0;
            ready_q      <= 1'b0;
            din_q        <= 16'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            word_q       <= word_d;
            wr_q         <= wr_d;
            lo_q         <= lo_d;
            sram_addr_q  <= sram_addr_d;
            sram_dq_o_q  <= sram_dq_o_d;
            sram_dq_oe_q <= sram_dq_oe_d;
            sram_ce_n_q  <= sram_ce_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
            sram_we_n_q  <= sram_we_n_d;
            io_addr_q    <= io_addr_d;
            io_wdata_q   <= io_wdata_d;
            io_word_q    <= io_word_d;
            io_rd_q      <= io_rd_d;
            io_wr_q      <= io_wr_d;
            ready_q      <= ready_d;
            din_q        <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        word_d  = word_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (cpu.rd || cpu.wr) begin
                    addr_d  = cpu.addr;
                    data_d  = cpu.dout;
                    word_d  = cpu.word;
                    wr_d    = cpu.wr;
                    cnt_d   = WS;
                    state_d = cpu.io ? S_IOS : S_B0;
                end
            end
            S_B0: begin
                if (!last_phase) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (!word_q) begin
                    state_d = S_RESP;
                end else if (wr_q) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_B1;
                    cnt_d   = WS;
                end
            end
            S_GAP: begin
                state_d = S_B1;
                cnt_d   = WS;
            end
            S_B1: begin
                if (!last_phase) cnt_d = cnt_q - 3'd1;
                else             state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            S_IOS:   state_d = S_IOW;
            S_IOW:   state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_phase_d  = (state_d == S_B0) || (state_d == S_B1);
        sram_ce_n_d  = !mem_phase_d;
        sram_oe_n_d  = !(mem_phase_d && !wr_d);
        sram_dq_oe_d = mem_phase_d && wr_d;
        // we_n releases one cycle before the phase ends so the address never moves under it
        sram_we_n_d  = !(mem_phase_d && wr_d && ((cnt_d != 3'd0) || (WS == 3'd0)));

        sram_addr_d = sram_addr_q;
        sram_dq_o_d = sram_dq_o_q;
        case (state_d)
            S_B0: begin
                sram_addr_d = addr_d;
                sram_dq_o_d = data_d[7:0];
            end
            S_GAP, S_B1: begin
                sram_addr_d = addr_d + 20'd1;
                sram_dq_o_d = data_d[15:8];
            end
            default: ;
        endcase

        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        io_word_d  = io_word_q;
        io_rd_d    = 1'b0;
        io_wr_d    = 1'b0;
        if (state_d == S_IOS) begin
            io_addr_d  = addr_d[15:0];
            io_wdata_d = data_d;
            io_word_d  = word_d;
            io_rd_d    = !wr_d;
            io_wr_d    = wr_d;
        end

        lo_d = lo_q;
        if (state_q == S_B0 && last_phase && !wr_q) lo_d = sram_dq_i;

        ready_d = (state_d == S_RESP);
        din_d   = 16'h0;
        if (state_d == S_RESP && !wr_q) begin
            case (state_q)
                S_IOW:   din_d = word_q ? io_rdata : {8'h00, io_rdata[7:0]};
                S_B0:    din_d = {8'h00, sram_dq_i};
                S_B1:    din_d = {sram_dq_i, lo_q};
                default: din_d = 16'h0;
            endcase
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = sram_dq_o_q;
    assign sram_dq_oe = sram_dq_oe_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign sram_we_n  = sram_we_n_q;
    assign io_addr    = io_addr_q;
    assign io_wdata   = io_wdata_q;
    assign io_word    = io_word_q;
    assign io_rd      = io_rd_q;
    assign io_wr      = io_wr_q;
    assign cpu.ready  = ready_q;
    assign cpu.din    = din_q;

endmodule

// File: tb/tb_z8086_sram_bridge.sv
// Directed bench for z8086_sram_bridge: one instance with WAIT_STATES=1, one with 0,
// sharing a byte-wide SRAM model; cycle 0 is the cycle the request pulse is high.
module tb_z8086_sram_bridge;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    z8086_sram_bridge_if cpu1();
    z8086_sram_bridge_if cpu0();

    logic [19:0] sram_addr1, sram_addr0;
    logic [7:0]  dq_o1, dq_o0, dq_i1, dq_i0;
    logic        dq_oe1, dq_oe0, ce1, ce0, oe1, oe0, we1, we0;
    logic [15:0] io_addr1, io_addr0, io_wdata1, io_wdata0;
    logic        io_word1, io_word0, io_rd1, io_rd0, io_wr1, io_wr0;
    logic [15:0] io_rdata1;
    logic [15:0] io_rdata0;
    logic [15:0] io_val;

    logic [7:0]  mem [0:1048575];
    logic        pl_en;
    logic [19:0] pl_addr;
    logic [7:0]  pl_val;
    int          viol;
    int          oe_cnt1;
    logic        prev_we1, prev_we0;
    logic [19:0] prev_addr1, prev_addr0;

    int n_cmp = 0;
    int n_fail = 0;

    z8086_sram_bridge #(.WAIT_STATES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cpu(cpu1.slave),
        .sram_addr(sram_addr1), .sram_dq_o(dq_o1), .sram_dq_oe(dq_oe1), .sram_dq_i(dq_i1),
        .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1),
        .io_addr(io_addr1), .io_wdata(io_wdata1), .io_word(io_word1),
        .io_rd(io_rd1), .io_wr(io_wr1), .io_rdata(io_rdata1)
    );

    z8086_sram_bridge #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cpu(cpu0.slave),
        .sram_addr(sram_addr0), .sram_dq_o(dq_o0), .sram_dq_oe(dq_oe0), .sram_dq_i(dq_i0),
        .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0),
        .io_addr(io_addr0), .io_wdata(io_wdata0), .io_word(io_word0),
        .io_rd(io_rd0), .io_wr(io_wr0), .io_rdata(io_rdata0)
    );

    assign dq_i1     = (!ce1 && !oe1) ? mem[sram_addr1] : 8'h00;
    assign dq_i0     = (!ce0 && !oe0) ? mem[sram_addr0] : 8'h00;
    assign io_rdata0 = 16'h0000;

    // SRAM write model, I/O responder and write-strobe/address-change monitor
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_val;
        else if (!ce1 && !we1 && dq_oe1) mem[sram_addr1] <= dq_o1;
        else if (!ce0 && !we0 && dq_oe0) mem[sram_addr0] <= dq_o0;
        io_rdata1 <= io_rd1 ? io_val : 16'h0000;
        if (!ce1 && !oe1) oe_cnt1 <= oe_cnt1 + 1;
        if (reset_n && ((!prev_we1 && sram_addr1 != prev_addr1) ||
                        (!prev_we0 && sram_addr0 != prev_addr0)))
            viol <= viol + 1;
        prev_we1   <= reset_n ? we1 : 1'b1;
        prev_we0   <= reset_n ? we0 : 1'b1;
        prev_addr1 <= sram_addr1;
        prev_addr0 <= sram_addr0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [19:0] a, input logic [7:0] v);
        pl_addr = a;
        pl_val  = v;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    task automatic drive(input bit sel, input bit r, input bit w, input bit i, input bit wd,
                         input logic [19:0] a, input logic [15:0] d);
        if (sel) begin
            cpu1.rd = r; cpu1.wr = w; cpu1.io = i; cpu1.word = wd; cpu1.addr = a; cpu1.dout = d;
        end else begin
            cpu0.rd = r; cpu0.wr = w; cpu0.io = i; cpu0.word = wd; cpu0.addr = a; cpu0.dout = d;
        end
    endtask

    // Issues a request in cycle 0 and watches cycles 1..20 for ready and io_rd.
    task automatic xact(input bit sel, input bit r, input bit w, input bit i, input bit wd,
                        input logic [19:0] a, input logic [15:0] d,
                        output int rcyc, output int npulse, output logic [15:0] dat,
                        output int iocyc, output logic [15:0] ioa);
        rcyc = -1; npulse = 0; dat = 16'h0; iocyc = -1; ioa = 16'h0;
        drive(sel, r, w, i, wd, a, d);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        for (int k = 1; k <= 20; k++) begin
            if (sel ? cpu1.ready : cpu0.ready) begin
                npulse++;
                if (rcyc < 0) begin
                    rcyc = k;
                    dat  = sel ? cpu1.din : cpu0.din;
                end
            end
            if (sel && io_rd1 && iocyc < 0) begin
                iocyc = k;
                ioa   = io_addr1;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int          rc, np, ioc, v0, oe0_snap, rdy_rst;
        logic [15:0] dat, ioa;

        reset_n = 1'b1;
        pl_en = 1'b0; pl_addr = 20'h0; pl_val = 8'h0;
        io_val = 16'h0; viol = 0; oe_cnt1 = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, cpu1.ready}, 32'h0);
        check("rst_din", {16'h0, cpu1.din}, 32'h0);
        check("rst_ce_n", {31'h0, ce1}, 32'h1);
        check("rst_oe_n", {31'h0, oe1}, 32'h1);
        check("rst_we_n", {31'h0, we1}, 32'h1);
        check("rst_dq_oe", {31'h0, dq_oe1}, 32'h0);
        check("rst_io_rd", {31'h0, io_rd1}, 32'h0);
        check("rst_sram_addr", {12'h0, sram_addr1}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        poke(20'h12345, 8'hAB);
        poke(20'h12346, 8'hCD);
        poke(20'h00010, 8'h11);
        poke(20'h00011, 8'h22);
        poke(20'hFFFFF, 8'h00);
        poke(20'h00000, 8'h00);
        poke(20'h00100, 8'h00);
        poke(20'h00200, 8'h00);
        poke(20'h00201, 8'h3C);

        // word read at odd address, W=1
        xact(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 20'h12345, 16'h0, rc, np, dat, ioc, ioa);
        check("wrd_rd_cycle", rc, 5);
        check("wrd_rd_pulses", np, 1);
        check("wrd_rd_din", {16'h0, dat}, 32'hCDAB);

        // word read, W=0
        xact(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h12345, 16'h0, rc, np, dat, ioc, ioa);
        check("w0_wrd_rd_cycle", rc, 3);
        check("w0_wrd_rd_din", {16'h0, dat}, 32'hCDAB);

        // byte write, W=0
        xact(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h77EE, rc, np, dat, ioc, ioa);
        check("byte_wr_cycle", rc, 2);
        check("byte_wr_pulses", np, 1);
        check("byte_wr_din", {16'h0, dat}, 32'h0);
        check("byte_wr_mem10", {24'h0, mem[20'h00010]}, 32'hEE);
        check("byte_wr_mem11", {24'h0, mem[20'h00011]}, 32'h22);

        // word write wrapping past the top of the address space, W=1
        v0 = viol;
        xact(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 20'hFFFFF, 16'h1234, rc, np, dat, ioc, ioa);
        check("wrap_wr_cycle", rc, 6);
        check("wrap_wr_pulses", np, 1);
        check("wrap_wr_memFFFFF", {24'h0, mem[20'hFFFFF]}, 32'h34);
        check("wrap_wr_mem00000", {24'h0, mem[20'h00000]}, 32'h12);
        check("wrap_wr_we_addr", viol - v0, 0);

        // byte I/O read
        io_val = 16'hFFFF;
        xact(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00060, 16'h0, rc, np, dat, ioc, ioa);
        check("io_rd_strobe_cycle", ioc, 1);
        check("io_rd_addr", {16'h0, ioa}, 32'h0060);
        check("io_rd_cycle", rc, 3);
        check("io_rd_din", {16'h0, dat}, 32'h00FF);

        // word I/O read
        io_val = 16'hBEEF;
        xact(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 20'h31234, 16'h0, rc, np, dat, ioc, ioa);
        check("io_wrd_rd_addr", {16'h0, ioa}, 32'h1234);
        check("io_wrd_rd_cycle", rc, 3);
        check("io_wrd_rd_din", {16'h0, dat}, 32'hBEEF);

        // rd and wr together: write wins
        oe0_snap = oe_cnt1;
        xact(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00100, 16'h0055, rc, np, dat, ioc, ioa);
        check("rdwr_mem100", {24'h0, mem[20'h00100]}, 32'h55);
        check("rdwr_no_read", oe_cnt1 - oe0_snap, 0);
        check("rdwr_pulses", np, 1);
        check("rdwr_cycle", rc, 3);

        // reset during the high-byte phase of a word write
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00200, 16'h5AA5);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_b1_we_n", {31'h0, we1}, 32'h0);
        check("mid_b1_addr", {12'h0, sram_addr1}, 32'h00201);
        reset_n = 1'b0;
        #1;
        check("abort_ce_n", {31'h0, ce1}, 32'h1);
        check("abort_we_n", {31'h0, we1}, 32'h1);
        check("abort_dq_oe", {31'h0, dq_oe1}, 32'h0);
        rdy_rst = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cpu1.ready) rdy_rst++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (cpu1.ready) rdy_rst++;
        end
        check("abort_no_ready", rdy_rst, 0);
        check("abort_mem200", {24'h0, mem[20'h00200]}, 32'hA5);
        check("abort_mem201", {24'h0, mem[20'h00201]}, 32'h3C);
        xact(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00200, 16'h0, rc, np, dat, ioc, ioa);
        check("post_rst_rd_cycle", rc, 3);
        check("post_rst_rd_din", {16'h0, dat}, 32'h00A5);
        check("we_addr_total", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
